// File: rtl/truth_table_sweeper_if.sv
// Handshake/result bundle between the truth-table sweeper and its driver.
// The master side drives start/abort, the function output and the expected table.
interface truth_table_sweeper_if #(
  parameter int N_IN = 2
);
  logic                   start;
  logic                   abort;
  logic                   func_in;
  logic [2**N_IN-1:0]     exp_table;
  logic [N_IN-1:0]        vec_out;
  logic                   busy;
  logic                   done;
  logic [2**N_IN-1:0]     table_out;
  logic                   pass;
  logic [N_IN:0]          fail_cnt;
  logic [N_IN-1:0]        fail_idx;

  modport master (
    output start, abort, func_in, exp_table,
    input  vec_out, busy, done, table_out, pass, fail_cnt, fail_idx
  );

  modport slave (
    input  start, abort, func_in, exp_table,
    output vec_out, busy, done, table_out, pass, fail_cnt, fail_idx
  );
endinterface

// File: rtl/truth_table_sweeper.sv
// Walks every input vector of an N_IN-input function, holds each for SETTLE
// cycles, captures the output into a truth table and checks it against exp_table.
//
// state | meaning
// IDLE  | waiting for start, outputs at reset values
// HOLD  | driving vec_out, counting down the settle window, sampling at zero
// CHECK | one cycle: compare captured table with exp_table, register results
// DONE  | results valid and held until the next start
module truth_table_sweeper #(
  parameter int N_IN   = 2,
  parameter int SETTLE = 1
) (
  input  logic clk,
  input  logic reset,
  truth_table_sweeper_if.slave bus
);
  localparam int              N_VEC    = 2**N_IN;
  localparam logic [N_IN-1:0] LAST_VEC = N_IN'(N_VEC-1);
  localparam logic [N_IN-1:0] VEC_ONE  = N_IN'(1);
  localparam logic [N_IN:0]   CNT_ONE  = (N_IN+1)'(1);
  localparam logic [3:0]      RELOAD   = 4'(SETTLE-1);

  typedef enum logic [1:0] {IDLE, HOLD, CHECK, DONE} state_t;

  state_t            state;
  logic [3:0]        settle_cnt;
  logic [N_IN-1:0]   vec;
  logic [N_VEC-1:0]  tbl;
  logic              busy_q;
  logic              done_q;
  logic              pass_q;
  logic [N_IN:0]     fail_cnt_q;
  logic [N_IN-1:0]   fail_idx_q;

  logic [N_VEC-1:0]  diff;
  logic [N_IN:0]     mism_cnt;
  logic [N_IN-1:0]   mism_idx;

  // Scanning from the top down leaves the lowest mismatching index in mism_idx.
  always_comb begin
    diff     = tbl ^ bus.exp_table;
    mism_cnt = '0;
    mism_idx = '0;
    for (int i = N_VEC-1; i >= 0; i--) begin
      if (diff[i]) begin
        mism_cnt = mism_cnt + CNT_ONE;
        mism_idx = N_IN'(i);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      settle_cnt <= '0;
      vec        <= '0;
      tbl        <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      fail_cnt_q <= '0;
      fail_idx_q <= '0;
    end else if (bus.abort && (state == HOLD || state == CHECK)) begin
      // Abort beats the sample that would otherwise land this cycle.
      state      <= IDLE;
      settle_cnt <= '0;
      vec        <= '0;
      tbl        <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      fail_cnt_q <= '0;
      fail_idx_q <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            state      <= HOLD;
            settle_cnt <= RELOAD;
            vec        <= '0;
            tbl        <= '0;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            fail_cnt_q <= '0;
            fail_idx_q <= '0;
          end
        end
        HOLD: begin
          if (settle_cnt == '0) begin
            tbl[vec] <= bus.func_in;
            if (vec == LAST_VEC) begin
              state <= CHECK;
            end else begin
              vec        <= vec + VEC_ONE;
              settle_cnt <= RELOAD;
            end
          end else begin
            settle_cnt <= settle_cnt - 4'd1;
          end
        end
        CHECK: begin
          pass_q     <= (mism_cnt == '0);
          fail_cnt_q <= mism_cnt;
          fail_idx_q <= mism_idx;
          busy_q     <= 1'b0;
          done_q     <= 1'b1;
          state      <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.vec_out   = vec;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.table_out = tbl;
  assign bus.pass      = pass_q;
  assign bus.fail_cnt  = fail_cnt_q;
  assign bus.fail_idx  = fail_idx_q;
endmodule

// File: doc/truth_table_sweeper.md
Name: truth_table_sweeper

Overview:
Upstream stimulus stage for the two-input logic-function modules in this codebase. On request, the block walks every input combination of an N_IN-input combinational function, holding each vector for a settle window. It samples the function's 1-bit output for each vector and accumulates the result into a truth-table register. It then compares that table against an expected table and reports pass/fail.

Parameters:
N_IN, 2, number of function inputs driven; vec_out[N_IN-1] is the MSB (x), vec_out[0] is the LSB (y).
SETTLE, 1, clock cycles each vector is held before sampling; legal range 1..15.

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
start  input  1  begin a sweep; honoured only in IDLE or DONE
abort  input  1  cancel a sweep in progress; returns to IDLE
func_in  input  1  output of the function under test (s)
exp_table  input  2**N_IN  expected output per vector; bit i is the expected output for vec_out==i
vec_out  output  N_IN  vector driven to the function inputs
busy  output  1  high while sweeping
done  output  1  high in DONE; table_out and the result outputs are valid
table_out  output  2**N_IN  captured truth table; bit i is func_in sampled for vector i
pass  output  1  table_out == exp_table; valid while done
fail_cnt  output  N_IN+1  count of mismatching bits
fail_idx  output  N_IN  lowest mismatching index; 0 when pass

Behaviour:
- Reset (asynchronous, any state): state=IDLE, and every output (vec_out, busy, done, table_out, pass, fail_cnt, fail_idx) = 0.
- States: IDLE, HOLD, CHECK, DONE.
- IDLE:
  - start=1 at edge k → HOLD at k+1 with vec_out=0, settle counter=SETTLE-1, table_out cleared, busy=1.
- HOLD:
  - vec_out is stable. The counter decrements each edge.
  - At the edge where the counter is 0: table_out[vec_out] <= func_in.
  - If vec_out == 2**N_IN-1: go to CHECK, busy stays 1.
  - Otherwise: vec_out <= vec_out+1 and the counter reloads to SETTLE-1.
  - Each vector is held exactly SETTLE cycles. Total HOLD duration is 2**N_IN*SETTLE cycles.
  - vec_out never wraps inside a sweep.
- CHECK (one cycle):
  - Registers pass, fail_cnt = popcount(table_out ^ exp_table), and fail_idx = lowest set bit of the XOR (0 if none).
  - exp_table is sampled only at this edge.
  - Next state is DONE with busy=0 and done=1.
- DONE:
  - Outputs hold. vec_out holds the last vector.
  - start=1 → HOLD, identical to starting from IDLE; done drops the following cycle.
- Start latency: busy rises 1 cycle after start. done rises 2**N_IN*SETTLE+1 cycles after busy rises.
- abort=1 in HOLD or CHECK:
  - Go to IDLE next edge: busy=0, done=0, vec_out=0, table_out=0, and all result outputs 0.
  - abort has priority over sampling in the same cycle.
  - In IDLE or DONE, abort is ignored.
- Simultaneous start and abort in IDLE/DONE: start wins (abort is ignored there).
- start while busy: ignored, no restart.
- func_in is treated as synchronous to clk. The settle window exists for the consumer's combinational depth; no synchroniser is provided.
- Reset mid-sweep: immediate return to IDLE with all outputs 0. No partial table is retained.

Test Plan:
- Reset mid-sweep: assert reset while in HOLD at vec_out=2 → outputs 0 immediately (before the next edge); after release, a start completes a normal sweep.
- AND function, N_IN=2, SETTLE=1, exp_table=4'b1000, pulse start → vec_out runs 0,1,2,3 on consecutive cycles; done after 5 cycles from busy; table_out=4'b1000, pass=1, fail_cnt=0, fail_idx=0.
- XOR function, exp_table=4'b0110 → pass=1. Rerun from DONE with exp_table=4'b0111 → pass=0, fail_cnt=1, fail_idx=0.
- Constant-1 function, SETTLE=3 → each vector held 3 cycles; busy high 13 cycles; table_out=4'b1111.
- Abort at the second HOLD cycle of vector 2 → IDLE next edge, all outputs 0. start asserted during busy in a separate run has no effect on the vec_out sequence.
